// File: rtl/sbn_pkg.sv
// Shared definitions for the subtract-and-branch-if-negative core:
// FSM states, default widths and instruction field offsets.
package sbn_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_PC_WIDTH   = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_RDA   = 3'd2,
      ST_RDB   = 3'd3,
      ST_EXEC  = 3'd4,
      ST_HALT  = 3'd5
   } sbn_state_t;

   // Instruction word is {A, B, C} with A in the MSBs.
   localparam int C_LSB = 0;

   function automatic int b_lsb(input int pc_width);
      return pc_width;
   endfunction

   function automatic int a_lsb(input int addr_width, input int pc_width);
      return addr_width + pc_width;
   endfunction

   function automatic int instr_width(input int addr_width, input int pc_width);
      return 2 * addr_width + pc_width;
   endfunction

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/sbn_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are not reset so the array maps onto block RAM.
module sbn_ram #(
   parameter int WIDTH = 32,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1 << AW) - 1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sbn_core.sv
// Single-instruction (SUBLEQ-style, branch on negative) processor core with
// separate instruction and data RAMs and a host load port usable while idle.
module sbn_core
   import sbn_pkg::*;
#(
   parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter  int PC_WIDTH    = DEF_PC_WIDTH,
   localparam int INSTR_WIDTH = instr_width(ADDR_WIDTH, PC_WIDTH),
   localparam int LD_AW       = max2(ADDR_WIDTH, PC_WIDTH),
   localparam int LD_DW       = max2(DATA_WIDTH, INSTR_WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                ld_en,
   input  logic                ld_sel,
   input  logic [LD_AW-1:0]    ld_addr,
   input  logic [LD_DW-1:0]    ld_data,
   output logic                busy,
   output logic                halted,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         icount
);

   localparam int A_LSB = a_lsb(ADDR_WIDTH, PC_WIDTH);
   localparam int B_LSB = b_lsb(PC_WIDTH);

   sbn_state_t             state_reg, state_next;
   logic [PC_WIDTH-1:0]    pc_reg, pc_next;
   logic [31:0]            icount_reg, icount_next;
   logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
   logic [DATA_WIDTH-1:0]  a_val_reg, a_val_next;

   logic                   imem_we;
   logic [PC_WIDTH-1:0]    imem_raddr;
   logic [INSTR_WIDTH-1:0] imem_rdata;

   logic                   dmem_we_c, dmem_we;
   logic [ADDR_WIDTH-1:0]  dmem_waddr;
   logic [DATA_WIDTH-1:0]  dmem_wdata;
   logic [ADDR_WIDTH-1:0]  dmem_raddr;
   logic [DATA_WIDTH-1:0]  dmem_rdata;

   logic                   load_ok;
   logic [DATA_WIDTH-1:0]  exec_diff;
   logic [ADDR_WIDTH-1:0]  fld_a, fld_b;
   logic [PC_WIDTH-1:0]    fld_c;

   assign fld_a     = instr_reg[A_LSB +: ADDR_WIDTH];
   assign fld_b     = instr_reg[B_LSB +: ADDR_WIDTH];
   assign fld_c     = instr_reg[C_LSB +: PC_WIDTH];
   assign exec_diff = a_val_reg - dmem_rdata;

   assign busy    = (state_reg == ST_FETCH) || (state_reg == ST_RDA) ||
                    (state_reg == ST_RDB)   || (state_reg == ST_EXEC);
   assign halted  = (state_reg == ST_HALT);
   assign pc      = pc_reg;
   assign icount  = icount_reg;
   assign load_ok = ld_en && !busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         pc_reg     <= '0;
         icount_reg <= '0;
         instr_reg  <= '0;
         a_val_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         icount_reg <= icount_next;
         instr_reg  <= instr_next;
         a_val_reg  <= a_val_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      icount_next = icount_reg;
      instr_next  = instr_reg;
      a_val_next  = a_val_reg;
      imem_raddr  = pc_reg;
      dmem_raddr  = fld_a;
      // Host load owns the write ports whenever the core is not executing.
      imem_we     = load_ok && !ld_sel;
      dmem_we_c   = load_ok && ld_sel;
      dmem_waddr  = ld_addr[ADDR_WIDTH-1:0];
      dmem_wdata  = ld_data[DATA_WIDTH-1:0];

      case (state_reg)
         ST_IDLE, ST_HALT: begin
            if (start && !ld_en) begin
               state_next  = ST_FETCH;
               pc_next     = '0;
               icount_next = '0;
            end
         end
         ST_FETCH: begin
            state_next = ST_RDA;
         end
         ST_RDA: begin
            // A must come straight off the RAM port to keep the 4-cycle cadence.
            instr_next = imem_rdata;
            dmem_raddr = imem_rdata[A_LSB +: ADDR_WIDTH];
            state_next = ST_RDB;
         end
         ST_RDB: begin
            a_val_next = dmem_rdata;
            dmem_raddr = fld_b;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            dmem_we_c  = 1'b1;
            dmem_waddr = fld_a;
            dmem_wdata = exec_diff;
            if (icount_reg != '1) begin
               icount_next = icount_reg + 32'd1;
            end
            if (exec_diff[DATA_WIDTH-1]) begin
               pc_next    = fld_c;
               state_next = (fld_c == pc_reg) ? ST_HALT : ST_FETCH;
            end else begin
               pc_next    = pc_reg + PC_WIDTH'(1);
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Block any RAM write while reset is held, including the EXEC write-back.
   assign dmem_we = dmem_we_c && !rst;

   sbn_ram #(
      .WIDTH (INSTR_WIDTH),
      .AW    (PC_WIDTH)
   ) u_imem (
      .clk   (clk),
      .we    (imem_we && !rst),
      .waddr (ld_addr[PC_WIDTH-1:0]),
      .wdata (ld_data[INSTR_WIDTH-1:0]),
      .raddr (imem_raddr),
      .rdata (imem_rdata)
   );

   sbn_ram #(
      .WIDTH (DATA_WIDTH),
      .AW    (ADDR_WIDTH)
   ) u_dmem (
      .clk   (clk),
      .we    (dmem_we),
      .waddr (dmem_waddr),
      .wdata (dmem_wdata),
      .raddr (dmem_raddr),
      .rdata (dmem_rdata)
   );

endmodule

// File: tb/tb_sbn_core.sv
// Self-checking bench for sbn_core: directed vector table, hand-written
// multi-cycle sequences and randomized programs against a behavioural model.
module tb_sbn_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ld_en = 1'b0;
   logic        ld_sel = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        busy;
   logic        halted;
   logic [7:0]  pc;
   logic [31:0] icount;

   int n_checks = 0;
   int n_pass = 0;

   sbn_core dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .ld_en   (ld_en),
      .ld_sel  (ld_sel),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .busy    (busy),
      .halted  (halted),
      .pc      (pc),
      .icount  (icount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] exp_mem;
      logic [7:0]  exp_pc;
      logic        exp_halt;
   } vec_t;

   vec_t vecs [6];

   logic [23:0] m_imem [0:255];
   logic [31:0] m_dmem [0:7];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic load(input logic sel, input logic [7:0] addr, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_sel  = sel;
      ld_addr = addr;
      ld_data = data;
      tick(1);
      ld_en   = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   function automatic logic [31:0] ins(input int a, input int b, input int c);
      logic [7:0] fa, fb, fc;
      fa = 8'(a);
      fb = 8'(b);
      fc = 8'(c);
      return {8'h00, fa, fb, fc};
   endfunction

   function automatic logic [31:0] dmem_at(input int addr);
      return dut.u_dmem.mem[addr];
   endfunction

   // Architectural model: executes up to n instructions by the ISA rules.
   task automatic model_run(input int n, output int m_pc, output int m_ic, output bit m_halt);
      int a, b, c;
      logic [31:0] r;
      m_pc = 0;
      m_ic = 0;
      m_halt = 0;
      for (int s = 0; s < n && !m_halt; s++) begin
         a = int'(m_imem[m_pc][23:16]);
         b = int'(m_imem[m_pc][15:8]);
         c = int'(m_imem[m_pc][7:0]);
         r = m_dmem[a] - m_dmem[b];
         m_dmem[a] = r;
         m_ic++;
         if ($signed(r) < 0) begin
            if (c == m_pc) m_halt = 1;
            m_pc = c;
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
      end
   endtask

   initial begin
      int m_pc, m_ic, n;
      bit m_halt;

      vecs[0] = '{8'd1, 8'd2, 8'd9, 32'd5,         32'd3,         32'd2,         8'd1, 1'b0};
      vecs[1] = '{8'd1, 8'd2, 8'd7, 32'd3,         32'd5,         32'hFFFF_FFFE, 8'd7, 1'b0};
      vecs[2] = '{8'd4, 8'd5, 8'd9, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 8'd1, 1'b0};
      vecs[3] = '{8'd6, 8'd7, 8'd0, 32'd0,         32'd1,         32'hFFFF_FFFF, 8'd0, 1'b1};
      vecs[4] = '{8'd1, 8'd1, 8'd0, 32'd7,         32'd7,         32'd0,         8'd1, 1'b0};
      vecs[5] = '{8'd2, 8'd3, 8'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 8'd3, 1'b0};

      tick(2);
      rst = 1'b0;
      tick(1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_pc", 32'(pc), 32'd0);
      check("reset_icount", icount, 32'd0);

      // Single-instruction vectors
      for (int i = 0; i < 6; i++) begin
         do_reset();
         load(1'b1, vecs[i].a, vecs[i].va);
         load(1'b1, vecs[i].b, vecs[i].vb);
         load(1'b0, 8'd0, ins(vecs[i].a, vecs[i].b, vecs[i].c));
         start_pulse();
         tick(4);
         $display("vec %0d: A=%0d B=%0d C=%0d -> mem=%0h pc=%0d halted=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].c, dmem_at(vecs[i].a), pc, halted);
         check($sformatf("vec%0d_mem", i), dmem_at(vecs[i].a), vecs[i].exp_mem);
         check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
         check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halt));
         check($sformatf("vec%0d_icount", i), icount, 32'd1);
      end

      // Two-instruction program halting at pc=1; a start during FETCH is ignored
      do_reset();
      load(1'b1, 8'd1, 32'd5);
      load(1'b1, 8'd2, 32'd3);
      load(1'b1, 8'd3, 32'd0);
      load(1'b1, 8'd4, 32'd1);
      load(1'b0, 8'd0, ins(1, 2, 0));
      load(1'b0, 8'd1, ins(3, 4, 1));
      start_pulse();
      check("seq1_busy", 32'(busy), 32'd1);
      tick(4);
      check("seq1_pc_after_1", 32'(pc), 32'd1);
      start_pulse();
      tick(2);
      check("seq1_not_halted_yet", 32'(halted), 32'd0);
      tick(1);
      $display("seq1: pc=%0d halted=%0d icount=%0d", pc, halted, icount);
      check("seq1_halted", 32'(halted), 32'd1);
      check("seq1_pc", 32'(pc), 32'd1);
      check("seq1_icount", icount, 32'd2);
      check("seq1_dmem1", dmem_at(1), 32'd2);
      check("seq1_dmem3", dmem_at(3), 32'hFFFF_FFFF);

      // Branch to 7 then halt there; restart from HALT clears state
      do_reset();
      load(1'b1, 8'd1, 32'd3);
      load(1'b1, 8'd2, 32'd5);
      load(1'b1, 8'd0, 32'd0);
      load(1'b1, 8'd6, 32'd1);
      load(1'b0, 8'd0, ins(1, 2, 7));
      load(1'b0, 8'd7, ins(0, 6, 7));
      start_pulse();
      tick(4);
      check("seq2_pc_branch", 32'(pc), 32'd7);
      tick(4);
      $display("seq2: pc=%0d halted=%0d dmem1=%0h", pc, halted, dmem_at(1));
      check("seq2_halted", 32'(halted), 32'd1);
      check("seq2_pc", 32'(pc), 32'd7);
      check("seq2_dmem1", dmem_at(1), 32'hFFFF_FFFE);
      check("seq2_icount", icount, 32'd2);
      start_pulse();
      check("seq2_restart_halted", 32'(halted), 32'd0);
      check("seq2_restart_pc", 32'(pc), 32'd0);
      check("seq2_restart_icount", icount, 32'd0);

      // pc wraps from 255 to 0 on a non-branching instruction
      do_reset();
      load(1'b1, 8'd20, 32'd0);
      load(1'b1, 8'd21, 32'd1);
      load(1'b1, 8'd22, 32'd5);
      load(1'b0, 8'd0, ins(20, 21, 255));
      load(1'b0, 8'd255, ins(22, 22, 0));
      start_pulse();
      tick(4);
      check("wrap_pc255", 32'(pc), 32'd255);
      tick(4);
      $display("wrap: pc=%0d icount=%0d", pc, icount);
      check("wrap_pc0", 32'(pc), 32'd0);
      check("wrap_dmem22", dmem_at(22), 32'd0);

      // Reset during RDB aborts the pending write-back
      do_reset();
      load(1'b1, 8'd1, 32'd5);
      load(1'b1, 8'd2, 32'd3);
      load(1'b0, 8'd0, ins(1, 2, 1));
      load(1'b0, 8'd1, ins(1, 2, 1));
      start_pulse();
      tick(4);
      check("abort_pc_before", 32'(pc), 32'd1);
      tick(2);
      rst = 1'b1;
      #1;
      $display("abort: busy=%0d pc=%0d", busy, pc);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      check("abort_icount", icount, 32'd0);
      tick(3);
      rst = 1'b0;
      tick(1);
      check("abort_dmem1", dmem_at(1), 32'd2);

      // Loads are ignored while busy and honoured when not
      do_reset();
      load(1'b1, 8'd1, 32'h11);
      load(1'b1, 8'd3, 32'd0);
      load(1'b1, 8'd4, 32'd1);
      load(1'b0, 8'd0, ins(3, 4, 0));
      start_pulse();
      load(1'b1, 8'd1, 32'hAA);
      tick(3);
      check("busyload_halted", 32'(halted), 32'd1);
      check("busyload_dmem1", dmem_at(1), 32'h11);
      load(1'b1, 8'd1, 32'hAA);
      $display("load: dmem1=%0h", dmem_at(1));
      check("idleload_dmem1", dmem_at(1), 32'hAA);

      // Load and start together: load wins, core stays put
      do_reset();
      start = 1'b1;
      load(1'b1, 8'd9, 32'h1234);
      start = 1'b0;
      check("ldstart_busy", 32'(busy), 32'd0);
      check("ldstart_dmem9", dmem_at(9), 32'h1234);

      // Randomized programs against the model
      for (int it = 0; it < 20; it++) begin
         do_reset();
         for (int i = 0; i < 256; i++) begin
            m_imem[i] = ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
            load(1'b0, 8'(i), 32'(m_imem[i]));
         end
         for (int i = 0; i < 8; i++) begin
            m_dmem[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8));
            load(1'b1, 8'(i), m_dmem[i]);
         end
         n = $urandom_range(1, 30);
         model_run(n, m_pc, m_ic, m_halt);
         start_pulse();
         tick(4 * n);
         $display("rand %0d: steps=%0d pc=%0d icount=%0d halted=%0d (model pc=%0d icount=%0d halted=%0d)",
                  it, n, pc, icount, halted, m_pc, m_ic, m_halt);
         check($sformatf("rand%0d_pc", it), 32'(pc), 32'(m_pc));
         check($sformatf("rand%0d_icount", it), icount, 32'(m_ic));
         check($sformatf("rand%0d_halted", it), 32'(halted), 32'(m_halt));
         check($sformatf("rand%0d_busy", it), 32'(busy), 32'(!m_halt));
         for (int i = 0; i < 8; i++) begin
            check($sformatf("rand%0d_dmem%0d", it, i), dmem_at(i), m_dmem[i]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
